wb_arbiter: RTL and testbench

- Writeback arbiter: the write-side initiator for the 32×32 register file.
- Merges two result streams, single-cycle ALU results and variable-latency load returns, onto the register file's single write port (`w_address`/`w_data`/`w_enable`).
- Load returns are buffered in a small FIFO.
- A starvation counter bounds how long loads wait behind back-to-back ALU results.

---
 rtl/wb_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges 1-cycle ALU results and FIFO-buffered loads onto one register-file write port.
// Registered w_* outputs; ALU stalls only when a load is granted. WB_BYPASS_EN adds the q_addr lookup.
module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic [4:0]  w_address,
    output logic [31:0] w_data,
    output logic        w_enable,
    output logic        busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  q_addr,
    output logic        q_hit,
    output logic [31:0] q_data
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_addr_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          w_enable_q, w_enable_d;
    logic [4:0]    w_address_q, w_address_d;
    logic [31:0]   w_data_q, w_data_d;

    logic fifo_empty, fifo_full, push, pop, grant_ld, grant_alu;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));

    // Grant depends only on registered FIFO state, so a fresh load never passes through in its push cycle.
    assign grant_ld  = !rst && !fifo_empty &&
                       (!alu_valid || fifo_full || starve_q == SW'(STARVE_LIMIT));
    assign grant_alu = alu_valid && !grant_ld;
    assign alu_ready = !grant_ld;
    assign ld_ready  = rst || !fifo_full;
    assign push      = ld_valid && !fifo_full;
    assign pop       = grant_ld;

    always_comb begin
        w_enable_d  = 1'b0;
        w_address_d = w_address_q;
        w_data_d    = w_data_q;
        if (grant_ld) begin
            w_enable_d  = 1'b1;
            w_address_d = fifo_addr_q[rd_ptr_q];
            w_data_d    = fifo_data_q[rd_ptr_q];
        end else if (grant_alu) begin
            w_enable_d  = 1'b1;
            w_address_d = alu_addr;
            w_data_d    = alu_data;
        end

        count_d = count_q + CW'(push) - CW'(pop);

        starve_d = starve_q;
        if (grant_ld || fifo_empty) begin
            starve_d = '0;
        end else if (grant_alu && starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            w_enable_q  <= 1'b0;
            w_address_q <= '0;
            w_data_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q     <= count_d;
            starve_q    <= starve_d;
            w_enable_q  <= w_enable_d;
            w_address_q <= w_address_d;
            w_data_q    <= w_data_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_addr_q[wr_ptr_q] <= ld_addr;
            fifo_data_q[wr_ptr_q] <= ld_data;
        end
    end

    assign w_enable  = w_enable_q;
    assign w_address = w_address_q;
    assign w_data    = w_data_q;
    assign busy      = !fifo_empty || w_enable_q;

`ifdef WB_BYPASS_EN
    logic [PW-1:0] q_idx;

    // Walk oldest to youngest so later matches override: youngest FIFO entry wins, output register loses.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        q_idx  = '0;
        if (q_addr != '0) begin
            if (w_enable_q && w_address_q == q_addr) begin
                q_hit  = 1'b1;
                q_data = w_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                q_idx = rd_ptr_q + PW'(i);
                if (CW'(i) < count_q && fifo_addr_q[q_idx] == q_addr) begin
                    q_hit  = 1'b1;
                    q_data = fifo_data_q[q_idx];
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a queue-based reference model checked every cycle.
module tb_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [4:0]  w_address;
    logic [31:0] w_data;
    logic        w_enable, busy;
`ifdef WB_BYPASS_EN
    logic [4:0]  q_addr;
    logic        q_hit;
    logic [31:0] q_data;
`endif

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .w_address(w_address), .w_data(w_data), .w_enable(w_enable), .busy(busy)
`ifdef WB_BYPASS_EN
        , .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending loads as a queue of {addr,data}, plus the visible write register.
    logic [36:0] ldq[$];
    int          m_starve = 0;
    logic        m_wen    = 1'b0;
    logic [4:0]  m_waddr  = '0;
    logic [31:0] m_wdata  = '0;

    function automatic bit model_grant_ld();
        return !rst && ldq.size() != 0 &&
               (!alu_valid || ldq.size() == DEPTH || m_starve == LIMIT);
    endfunction

    initial begin : model
        bit gld, galu, was_empty;
        forever begin
            @(posedge clk);
            if (rst) begin
                ldq.delete();
                m_starve = 0;
                m_wen    = 1'b0;
                m_waddr  = '0;
                m_wdata  = '0;
            end else begin
                gld       = model_grant_ld();
                galu      = alu_valid && !gld;
                was_empty = (ldq.size() == 0);
                if (ld_valid && ldq.size() < DEPTH) ldq.push_back({ld_addr, ld_data});
                if (gld) begin
                    m_wen = 1'b1;
                    {m_waddr, m_wdata} = ldq.pop_front();
                end else if (galu) begin
                    m_wen   = 1'b1;
                    m_waddr = alu_addr;
                    m_wdata = alu_data;
                end else begin
                    m_wen = 1'b0;
                end
                if (gld || was_empty) m_starve = 0;
                else if (galu && m_starve < LIMIT) m_starve++;
            end
        end
    end

    initial begin : compare
        bit gld;
`ifdef WB_BYPASS_EN
        logic        eh;
        logic [31:0] ed;
`endif
        @(posedge clk);
        forever begin
            @(negedge clk);
            gld = model_grant_ld();
            check("alu_ready", {31'b0, alu_ready}, {31'b0, !gld});
            check("ld_ready", {31'b0, ld_ready}, {31'b0, rst || ldq.size() < DEPTH});
            check("busy", {31'b0, busy}, {31'b0, ldq.size() != 0 || m_wen});
            check("w_enable", {31'b0, w_enable}, {31'b0, m_wen});
            check("w_address", {27'b0, w_address}, {27'b0, m_waddr});
            check("w_data", w_data, m_wdata);
`ifdef WB_BYPASS_EN
            eh = 1'b0;
            ed = '0;
            if (q_addr != 5'd0) begin
                if (m_wen && m_waddr == q_addr) begin
                    eh = 1'b1;
                    ed = m_wdata;
                end
                foreach (ldq[i]) begin
                    if (ldq[i][36:32] == q_addr) begin
                        eh = 1'b1;
                        ed = ldq[i][31:0];
                    end
                end
            end
            check("q_hit", {31'b0, q_hit}, {31'b0, eh});
            check("q_data", q_data, ed);
`endif
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ldd);
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        ld_valid  = lv;
        ld_addr   = la;
        ld_data   = ldd;
    endtask

    task automatic expect_w(input string nm, input logic en, input logic [4:0] a, input logic [31:0] d);
        check({nm, "_en"}, {31'b0, w_enable}, {31'b0, en});
        check({nm, "_addr"}, {27'b0, w_address}, {27'b0, a});
        check({nm, "_data"}, w_data, d);
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (n) cyc();
    endtask

    initial begin : stim
        int  k;
        bit  acc;
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef WB_BYPASS_EN
        q_addr = 5'd0;
`endif
        cyc();
        cyc();
        rst = 1'b0;
        expect_w("reset", 1'b0, 5'd0, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_ld_ready", {31'b0, ld_ready}, 32'd1);

        // ALU only, including a write to r0 that is forwarded unchanged
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        #2 check("alu_only_ready", {31'b0, alu_ready}, 32'd1);
        cyc();
        expect_w("alu_r5", 1'b1, 5'd5, 32'h1234);
        drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        cyc();
        expect_w("alu_r0", 1'b1, 5'd0, 32'hDEAD);
        idle(1);
        expect_w("alu_idle_hold", 1'b0, 5'd0, 32'hDEAD);
        check("alu_idle_busy", {31'b0, busy}, 32'd0);

        // Starvation: load r7 forced after exactly LIMIT ALU grants
        k = 0;
        for (int c = 0; c < 7; c++) begin
            drive(c < 6, 5'(10 + k), 32'h100 + k, c == 0, 5'd7, 32'hAAAA);
            #2;
            if (c == 4) check("starve_alu_ready", {31'b0, alu_ready}, 32'd0);
            acc = alu_valid && alu_ready;
            cyc();
            if (acc) k++;
            if (c == 3) expect_w("starve_alu3", 1'b1, 5'd13, 32'h103);
            if (c == 4) expect_w("starve_ld", 1'b1, 5'd7, 32'hAAAA);
            if (c == 5) expect_w("starve_held", 1'b1, 5'd14, 32'h104);
        end
        idle(2);

        // Full FIFO: load wins immediately despite starve count below limit
        k = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 5'(16 + k), 32'h200 + k, c < 2, (c == 0) ? 5'd8 : 5'd9,
                  (c == 0) ? 32'h808 : 32'h909);
            #2;
            if (c == 2) begin
                check("full_ld_ready", {31'b0, ld_ready}, 32'd0);
                check("full_alu_ready", {31'b0, alu_ready}, 32'd0);
            end
            if (c == 3) check("full_ld_ready_back", {31'b0, ld_ready}, 32'd1);
            acc = alu_valid && alu_ready;
            cyc();
            if (acc) k++;
            if (c == 2) expect_w("full_ld8", 1'b1, 5'd8, 32'h808);
            if (c == 3) expect_w("full_alu2", 1'b1, 5'd18, 32'h202);
            if (c == 6) expect_w("full_ld9", 1'b1, 5'd9, 32'h909);
        end
        idle(3);

        // Push and pop in the same cycle
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h1111);
        cyc();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h2222);
        cyc();
        expect_w("pushpop_ld1", 1'b1, 5'd1, 32'h1111);
        idle(1);
        expect_w("pushpop_ld2", 1'b1, 5'd2, 32'h2222);
        idle(1);
        check("pushpop_drained", {31'b0, busy}, 32'd0);

        // Reset with the FIFO full
        drive(1'b1, 5'd24, 32'h2424, 1'b1, 5'd25, 32'h2525);
        cyc();
        drive(1'b1, 5'd26, 32'h2626, 1'b1, 5'd27, 32'h2727);
        cyc();
        rst = 1'b1;
        #2;
        check("rst_alu_ready", {31'b0, alu_ready}, 32'd1);
        check("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
        cyc();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_w("rst_full", 1'b0, 5'd0, 32'd0);
        check("rst_full_busy", {31'b0, busy}, 32'd0);
        check("rst_full_ld_ready", {31'b0, ld_ready}, 32'd1);
        idle(2);

        // Reset mid-flight: pending r21 must never be written
        drive(1'b1, 5'd20, 32'h2020, 1'b1, 5'd21, 32'h2121);
        cyc();
        expect_w("mid_alu20", 1'b1, 5'd20, 32'h2020);
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("mid_no_write", {31'b0, w_enable}, 32'd0);
            cyc();
        end
        drive(1'b1, 5'd22, 32'h2222, 1'b0, 5'd0, 32'd0);
        cyc();
        expect_w("mid_new_alu", 1'b1, 5'd22, 32'h2222);
        idle(2);

`ifdef WB_BYPASS_EN
        // Bypass: FIFO entry for r3 shadows the output register's older r3 value
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        cyc();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        q_addr = 5'd3;
        #1;
        check("byp_hit", {31'b0, q_hit}, 32'd1);
        check("byp_data", q_data, 32'h22);
        q_addr = 5'd0;
        #1;
        check("byp_zero_hit", {31'b0, q_hit}, 32'd0);
        check("byp_zero_data", q_data, 32'd0);
        q_addr = 5'd3;
        idle(2);
        q_addr = 5'd0;
        idle(1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
